// File: rtl/pruning_ctrl_if.sv
// Host config/status, source-SRAM read, pruning-datapath and dest-SRAM write signals of pruning_ctrl.
// master is the controller side; slave is the host/SRAM/datapath side.
interface pruning_ctrl_if #(
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int addr_bw = 11
);
  logic                  start;
  logic                  abort;
  logic [addr_bw-1:0]    num_words;
  logic [addr_bw-1:0]    src_base;
  logic [addr_bw-1:0]    dst_base;
  logic                  rd_cen;
  logic [addr_bw-1:0]    rd_addr;
  logic                  prune_begin;
  logic [bw*col-1:0]     prune_out;
  logic                  wr_cen;
  logic                  wr_wen;
  logic [addr_bw-1:0]    wr_addr;
  logic [bw*col-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic [addr_bw+3:0]    zero_cnt;

  modport master (
    input  start, abort, num_words, src_base, dst_base, prune_out,
    output rd_cen, rd_addr, prune_begin, wr_cen, wr_wen, wr_addr, wr_data,
           busy, done, zero_cnt
  );

  modport slave (
    output start, abort, num_words, src_base, dst_base, prune_out,
    input  rd_cen, rd_addr, prune_begin, wr_cen, wr_wen, wr_addr, wr_data,
           busy, done, zero_cnt
  );
endinterface

// File: rtl/pruning_ctrl.sv
// Streams num_words words source SRAM -> pruning datapath -> dest SRAM at one word per cycle, counting zeroed elements.
// Write k lands rd_lat+prune_lat cycles after read k; no backpressure, abort flushes all in-flight words.
module pruning_ctrl #(
  parameter int col       = 8,
  parameter int bw        = 4,
  parameter int addr_bw   = 11,
  parameter int prune_lat = 1,
  parameter int rd_lat    = 1
) (
  input  logic           clk,
  input  logic           reset,
  pruning_ctrl_if.master bus
);
  localparam int lat  = rd_lat + prune_lat;
  localparam int zc_w = addr_bw + 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [addr_bw-1:0] num_words;
    logic [addr_bw-1:0] src_base;
    logic [addr_bw-1:0] dst_base;
  } cfg_t;

  state_t             state;
  cfg_t               cfg;
  logic [addr_bw-1:0] rd_cnt;
  logic [addr_bw-1:0] wr_cnt;
  logic [addr_bw-1:0] rd_addr_q;
  logic               rd_cen_q;
  logic               prune_begin_q;
  logic               busy_q;
  logic               done_q;
  logic [lat-1:0]     vld_pipe;
  logic [zc_w-1:0]    zero_cnt_q;
  logic [zc_w-1:0]    zeros_in_word;
  logic               wr_fire;

  assign wr_fire = vld_pipe[lat-1];

  always_comb begin
    zeros_in_word = '0;
    for (int i = 0; i < col; i++) begin
      if (bus.prune_out[i*bw +: bw] == '0) zeros_in_word = zeros_in_word + zc_w'(1);
    end
  end

  // rd_cnt holds the number of reads already issued, so ISSUE ends when it equals num_words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cfg           <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      rd_addr_q     <= '0;
      rd_cen_q      <= 1'b1;
      prune_begin_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      vld_pipe      <= '0;
      zero_cnt_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      vld_pipe <= {vld_pipe[lat-2:0], ~rd_cen_q};
      if (wr_fire) begin
        wr_cnt     <= wr_cnt + addr_bw'(1);
        zero_cnt_q <= zero_cnt_q + zeros_in_word;
      end

      if (bus.abort && state != IDLE) begin
        state         <= IDLE;
        rd_cen_q      <= 1'b1;
        vld_pipe      <= '0;
        prune_begin_q <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              cfg        <= '{num_words: bus.num_words, src_base: bus.src_base,
                              dst_base: bus.dst_base};
              wr_cnt     <= '0;
              zero_cnt_q <= '0;
              rd_addr_q  <= bus.src_base;
              busy_q     <= 1'b1;
              if (bus.num_words == '0) begin
                state <= DONE;
              end else begin
                state         <= ISSUE;
                rd_cen_q      <= 1'b0;
                rd_cnt        <= addr_bw'(1);
                prune_begin_q <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (rd_cnt == cfg.num_words) begin
              state    <= DRAIN;
              rd_cen_q <= 1'b1;
            end else begin
              rd_addr_q <= cfg.src_base + rd_cnt;
              rd_cnt    <= rd_cnt + addr_bw'(1);
            end
          end
          DRAIN: begin
            // Only the tap may still be set: the final write is happening this cycle.
            if (vld_pipe[lat-2:0] == '0) begin
              state         <= DONE;
              prune_begin_q <= 1'b0;
            end
          end
          DONE: begin
            state  <= IDLE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_cen      = rd_cen_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.prune_begin = prune_begin_q;
  assign bus.wr_cen      = ~wr_fire;
  assign bus.wr_wen      = ~wr_fire;
  assign bus.wr_addr     = cfg.dst_base + wr_cnt;
  assign bus.wr_data     = bus.prune_out;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.zero_cnt    = zero_cnt_q;
endmodule
